// File: rtl/mem_pkg.sv
// Purpose: shared encodings for the MEM-stage load/store unit (access sizes, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    // MemSize encodings; 2'b11 is reserved and handled as a word access
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } memState_t;

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Purpose: picks the addressed byte/half lane out of a bus word and zero/sign-extends it.
// Latency: purely combinational.
// Backpressure: none; result follows the inputs.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] result
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    assign byteLane = rdata[{addrLo, 3'b000} +: 8];
    // Half accesses select by a[1] only; a[0] is ignored
    assign halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane according to size and signedness
    always_comb begin
        result = rdata;
        case (size)
            SZ_BYTE: result = {{24{isSigned & byteLane[7]}}, byteLane};
            SZ_HALF: result = {{16{isSigned & halfLane[15]}}, halfLane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage load/store unit driving a req/ack data bus; optional MISALIGN_TRAP_EN traps misaligned half/word.
// Latency: 3 cycles minimum (IDLE issue, BUSY until ack or timeout, DONE), ReadData valid in DONE.
// Backpressure: mem_stall holds the pipeline from op issue through BUSY; released for the single DONE cycle.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] alu_result,
    input  logic [31:0] WriteData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadData,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        misalign
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    memState_t       state;
    memState_t       nextState;
    logic [TO_W-1:0] counter;

    logic            op;
    logic            trapNow;
    logic            timeoutHit;
    logic [3:0]      beNow;
    logic [31:0]     wdataNow;
    logic [1:0]      latAddrLo;
    logic [1:0]      latSize;
    logic            latSigned;
    logic [31:0]     loadValue;

    assign op         = MemRead | MemWrite;
    assign mem_req    = (state == BUSY);
    assign timeoutHit = (state == BUSY) && !mem_ack && (counter == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
    logic misalignReg;

    // Half with odd address, or word/reserved with any low address bit, never reaches the bus
    assign trapNow  = ((MemSize == SZ_HALF) && alu_result[0]) ||
                      ((MemSize[1] == 1'b1) && (alu_result[1:0] != 2'b00));
    assign misalign = misalignReg;

    // Misalign flag is raised for exactly the DONE cycle that follows a trapped op
    always_ff @(posedge clk) begin
        if (!reset) misalignReg <= 1'b0;
        else        misalignReg <= (state == IDLE) && op && trapNow;
    end
`else
    assign trapNow  = 1'b0;
    assign misalign = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the op presented in IDLE
    always_comb begin
        beNow    = 4'b1111;
        wdataNow = WriteData;
        case (MemSize)
            SZ_BYTE: begin
                beNow    = 4'b0001 << alu_result[1:0];
                wdataNow = {4{WriteData[7:0]}};
            end
            SZ_HALF: begin
                beNow    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdataNow = {2{WriteData[15:0]}};
            end
            default: begin
                beNow    = 4'b1111;
                wdataNow = WriteData;
            end
        endcase
    end

    // Next-state and stall: stall is raised combinationally as soon as an op shows up in IDLE
    always_comb begin
        nextState = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (op) begin
                    mem_stall = 1'b1;
                    nextState = trapNow ? DONE : BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (mem_ack || timeoutHit) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Timeout counter runs only while waiting for ack
    always_ff @(posedge clk) begin
        if (!reset || state != BUSY) counter <= '0;
        else                         counter <= counter + TO_W'(1);
    end

    // Latch the bus request when the op is accepted so it stays stable through BUSY
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            latAddrLo <= '0;
            latSize   <= '0;
            latSigned <= 1'b0;
        end else if (state == IDLE && op) begin
            mem_addr  <= {alu_result[31:2], 2'b00};
            mem_be    <= beNow;
            mem_wdata <= wdataNow;
            mem_we    <= MemWrite & ~MemRead;   // a simultaneous read/write request is a read
            latAddrLo <= alu_result[1:0];
            latSize   <= MemSize;
            latSigned <= MemSigned;
        end
    end

    load_formatter u_load_formatter (
        .rdata    (mem_rdata),
        .addrLo   (latAddrLo),
        .size     (latSize),
        .isSigned (latSigned),
        .result   (loadValue)
    );

    // Result capture: load data on ack, zero on timeout or trap; bus_err is a one-cycle pulse seen in DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            ReadData <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (state == BUSY) begin
                if (mem_ack) begin
                    if (!mem_we) ReadData <= loadValue;
                end else if (timeoutHit) begin
                    ReadData <= '0;
                    bus_err  <= 1'b1;
                end
            end else if (state == IDLE && op && trapNow) begin
                ReadData <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit using a byte-arithmetic reference model.
// Latency: checks IDLE/BUSY/DONE occupancy and timeout with TIMEOUT_CYCLES=4.
// Backpressure: checks mem_stall high through issue and BUSY, low for DONE.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, MemSigned;
    logic [1:0]  MemSize;
    logic [31:0] alu_result, WriteData;
    logic        mem_req, mem_we, mem_ack, mem_stall, bus_err, misalign;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ReadData;
    logic [3:0]  mem_be;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] lastRead = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .alu_result(alu_result), .WriteData(WriteData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ReadData(ReadData), .mem_stall(mem_stall), .bus_err(bus_err), .misalign(misalign)
    );

    // Reference: access width in bytes, aligned-down offset, shift/mask/extend
    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [1:0] sz, input logic sgn);
        int nb, off;
        logic [63:0] v, mask;
        nb   = sizeBytes(sz);
        off  = (int'(addr[1:0]) / nb) * nb;
        v    = {32'd0, rdata} >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (sgn && nb < 4 && (((v >> (8 * nb - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic idleInputs();
        MemRead = 0; MemWrite = 0; MemSize = 0; MemSigned = 0;
        alu_result = 0; WriteData = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    // One complete access: issue in IDLE, ack after ackDelay extra BUSY cycles (or never), check DONE
    task automatic doAccess(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ackDelay, input logic noAck,
                            output int stallCnt);
        logic        expWe;
        logic [3:0]  expBe;
        logic [31:0] expWd, expAddr, expRd;
        int          nb, off, busyN;
        nb      = sizeBytes(sz);
        off     = (int'(addr[1:0]) / nb) * nb;
        expWe   = wr & ~rd;
        expBe   = 4'(((1 << nb) - 1) << off);
        expAddr = addr & 32'hFFFF_FFFC;
        expWd   = (nb == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                  (nb == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        stallCnt = 0;

        @(negedge clk);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sgn;
        alu_result = addr; WriteData = wd; mem_ack = 0;
        #1;
        if (mem_stall) stallCnt++;
        nChecks++; if (mem_stall !== 1'b1) $display("FAIL %s issue_stall: got %b want 1", tag, mem_stall); else nPass++;
        nChecks++; if (mem_req !== 1'b0) $display("FAIL %s issue_req: got %b want 0", tag, mem_req); else nPass++;
        nChecks++; if (bus_err !== 1'b0) $display("FAIL %s issue_buserr: got %b want 0", tag, bus_err); else nPass++;

        busyN = noAck ? 4 : ackDelay + 1;
        for (int k = 0; k < busyN; k++) begin
            @(negedge clk);
            // Garbage on the pipeline inputs: the bus side must hold the latched request
            MemRead = 0; MemWrite = 0; MemSize = 2'($urandom);
            alu_result = $urandom; WriteData = $urandom;
            mem_ack   = (!noAck && k == ackDelay);
            mem_rdata = mem_ack ? rdata : $urandom;
            #1;
            if (mem_stall) stallCnt++;
            nChecks++; if (mem_req !== 1'b1) $display("FAIL %s busy_req c%0d: got %b want 1", tag, k, mem_req); else nPass++;
            nChecks++; if (mem_stall !== 1'b1) $display("FAIL %s busy_stall c%0d: got %b want 1", tag, k, mem_stall); else nPass++;
            nChecks++; if (mem_we !== expWe) $display("FAIL %s we: got %b want %b", tag, mem_we, expWe); else nPass++;
            nChecks++; if (mem_addr !== expAddr) $display("FAIL %s addr: got %h want %h", tag, mem_addr, expAddr); else nPass++;
            nChecks++; if (mem_be !== expBe) $display("FAIL %s be: got %b want %b", tag, mem_be, expBe); else nPass++;
            if (expWe) begin
                nChecks++; if (mem_wdata !== expWd) $display("FAIL %s wdata: got %h want %h", tag, mem_wdata, expWd); else nPass++;
            end
        end

        @(negedge clk);
        mem_ack = 0;
        #1;
        if (mem_stall) stallCnt++;
        expRd = modelLoad(rdata, addr, sz, sgn);
        if (noAck)       lastRead = 32'h0;
        else if (!expWe) lastRead = expRd;
        nChecks++; if (mem_stall !== 1'b0) $display("FAIL %s done_stall: got %b want 0", tag, mem_stall); else nPass++;
        nChecks++; if (mem_req !== 1'b0) $display("FAIL %s done_req: got %b want 0", tag, mem_req); else nPass++;
        nChecks++; if (ReadData !== lastRead) $display("FAIL %s ReadData: got %h want %h", tag, ReadData, lastRead); else nPass++;
        nChecks++; if (bus_err !== noAck) $display("FAIL %s bus_err: got %b want %b", tag, bus_err, noAck); else nPass++;
        nChecks++; if (misalign !== 1'b0) $display("FAIL %s misalign: got %b want 0", tag, misalign); else nPass++;
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 0;
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        mem_ack = 0;
        #1;
        nChecks++; if ({mem_req, mem_we, mem_stall, bus_err, misalign} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {mem_req, mem_we, mem_stall, bus_err, misalign}); else nPass++;
        nChecks++; if ({mem_addr, mem_wdata, ReadData, mem_be} !== 100'b0)
            $display("FAIL reset_data: addr %h wdata %h rd %h be %b want all 0", mem_addr, mem_wdata, ReadData, mem_be); else nPass++;
        @(negedge clk);
        reset = 1;
        lastRead = 32'h0;
    endtask

    task automatic test_lw();
        int sc;
        doAccess("lw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 0, sc);
        nChecks++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL lw_value: got %h want deadbeef", ReadData); else nPass++;
        nChecks++; if (sc !== 3) $display("FAIL lw_stall_cycles: got %0d want 3", sc); else nPass++;
        doAccess("lw_min", 1, 0, 2'b10, 0, 32'h104, 32'h0, 32'h1234_5678, 0, 0, sc);
        nChecks++; if (sc !== 2) $display("FAIL lw_min_stall_cycles: got %0d want 2", sc); else nPass++;
    endtask

    task automatic test_lb();
        int sc;
        doAccess("lb", 1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h8011_2233, 0, 0, sc);
        nChecks++; if (ReadData !== 32'hFFFF_FF80) $display("FAIL lb_value: got %h want ffffff80", ReadData); else nPass++;
        doAccess("lbu", 1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h8011_2233, 2, 0, sc);
        nChecks++; if (ReadData !== 32'h0000_0080) $display("FAIL lbu_value: got %h want 00000080", ReadData); else nPass++;
    endtask

    task automatic test_sh();
        int sc;
        doAccess("sh", 0, 1, 2'b01, 0, 32'h102, 32'h0000_ABCD, 32'h0, 1, 0, sc);
        nChecks++; if (ReadData !== 32'h0000_0080) $display("FAIL sh_keeps_ReadData: got %h want 00000080", ReadData); else nPass++;
    endtask

    task automatic test_timeout();
        int sc;
        doAccess("timeout", 1, 0, 2'b10, 0, 32'h200, 32'h0, 32'h0, 0, 1, sc);
        nChecks++; if (sc !== 5) $display("FAIL timeout_stall_cycles: got %0d want 5", sc); else nPass++;
        // Following access verifies bus_err lasted only one cycle and the unit recovered
        doAccess("after_timeout", 1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h8001_7FFF, 0, 0, sc);
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        MemRead = 1; MemSize = 2'b10; alu_result = 32'h300;
        @(negedge clk);
        MemRead = 0;
        #1;
        nChecks++; if (mem_req !== 1'b1) $display("FAIL rstbusy_req_before: got %b want 1", mem_req); else nPass++;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        lastRead = 32'h0;
        #1;
        nChecks++; if (mem_req !== 1'b0) $display("FAIL rstbusy_req_after: got %b want 0", mem_req); else nPass++;
        nChecks++; if (mem_stall !== 1'b0) $display("FAIL rstbusy_stall: got %b want 0", mem_stall); else nPass++;
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 0;
        #1;
        nChecks++; if (ReadData !== 32'h0) $display("FAIL rstbusy_late_ack: got %h want 00000000", ReadData); else nPass++;
        nChecks++; if (mem_req !== 1'b0 || mem_stall !== 1'b0) $display("FAIL rstbusy_idle: req %b stall %b want 0 0", mem_req, mem_stall); else nPass++;
    endtask

    // Randomized back-to-back traffic, including read+write collisions and the reserved size
    task automatic test_back_to_back();
        int sc;
        logic rd, wr;
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom);
            wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            doAccess($sformatf("rand%0d", i), rd, wr, 2'($urandom), 1'($urandom),
                     $urandom, $urandom, $urandom, $urandom_range(0, 2), 0, sc);
        end
    endtask

    initial begin
        reset = 0;
        idleInputs();
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
